// File: rtl/rob_wb_arbiter.sv
// Round-robin writeback arbiter: grants one functional-unit result per cycle into a
// one-entry output register that the ROB drains under a valid/ready handshake.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module rob_wb_arbiter #(
  parameter int unsigned WORD_SIZE   = `WORD_SIZE,
  parameter int unsigned ROB_ENTRIES = 10,
  parameter int unsigned NUM_REQ     = 4,
  localparam int unsigned TAG_W      = $clog2(ROB_ENTRIES),
  localparam int unsigned PTR_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         flush,
  output logic                         wb_valid,
  output logic [TAG_W-1:0]             wb_tag,
  output logic [WORD_SIZE-1:0]         wb_data,
  input  logic                         wb_ready,
  output logic [15:0]                  grant_cnt
);

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]     wb_tag_q, wb_tag_d;
  logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
  logic [15:0]          grant_cnt_q, grant_cnt_d;

  logic                 load;
  logic                 sel_found;
  logic [PTR_W-1:0]     sel_idx;
  logic                 transfer;

  // rst is folded in so req_ready is forced low asynchronously during reset
  assign load     = rst && !flush && (!wb_valid_q || wb_ready);
  assign transfer = load && sel_found;

  always_comb begin
    int unsigned idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[sel_idx] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    wb_valid_d  = wb_valid_q;
    wb_tag_d    = wb_tag_q;
    wb_data_d   = wb_data_q;
    grant_cnt_d = grant_cnt_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (transfer) begin
      wb_valid_d = 1'b1;
      wb_tag_d   = req_tag[sel_idx*TAG_W +: TAG_W];
      wb_data_d  = req_data[sel_idx*WORD_SIZE +: WORD_SIZE];
      ptr_d      = (32'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + 1'b1;
      if (grant_cnt_q != 16'hFFFF) grant_cnt_d = grant_cnt_q + 16'd1;
    end else if (wb_valid_q && wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_tag_q    <= '0;
      wb_data_q   <= '0;
      grant_cnt_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      wb_valid_q  <= wb_valid_d;
      wb_tag_q    <= wb_tag_d;
      wb_data_q   <= wb_data_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_tag    = wb_tag_q;
  assign wb_data   = wb_data_q;
  assign grant_cnt = grant_cnt_q;

endmodule
